// File: rtl/resp_router_pkg.sv
// Shared types and constants for the read-response router.
package resp_router_pkg;

    localparam int DEF_MASTER_NUM = 4;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_BEATS_W    = 4;

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_MSEL_W = safe_clog2(DEF_MASTER_NUM);

    // One outstanding read: which master asked, and how many beats (minus one) it expects.
    typedef struct packed {
        logic [DEF_MSEL_W-1:0]  master;
        logic [DEF_BEATS_W-1:0] len;
    } rd_entry_t;

endpackage

// File: rtl/resp_id_fifo.sv
// Order-preserving FIFO of outstanding read entries. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module resp_id_fifo
    import resp_router_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = rd_entry_t,
    localparam int IDX_W   = safe_clog2(DEPTH),
    localparam int PTR_W   = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  entry_t           din,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IDX_W-1:0]];

    // Pointers wrap naturally modulo 2*DEPTH; reset only clears control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset: empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
    end

endmodule

// File: rtl/resp_router.sv
// Steers each returning read-response beat to the master that issued the
// matching request, tracking burst beats and flagging protocol errors.
module resp_router
    import resp_router_pkg::*;
#(
    parameter int  MASTER_NUM = DEF_MASTER_NUM,
    parameter int  MSEL_W     = safe_clog2(MASTER_NUM),
    parameter int  DEPTH      = DEF_DEPTH,
    parameter int  BEATS_W    = DEF_BEATS_W,
    localparam int CNT_W      = safe_clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  rd_req,
    input  logic [MSEL_W-1:0]     rd_master,
    input  logic [BEATS_W-1:0]    rd_len,
    output logic                  rd_ready,
    input  logic                  resp,
    output logic [MASTER_NUM-1:0] resp_en,
    output logic                  resp_last,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  err_unexpected,
    output logic                  err_overflow
);

    typedef struct packed {
        logic [MSEL_W-1:0]  master;
        logic [BEATS_W-1:0] len;
    } entry_t;

    entry_t             push_entry;
    entry_t             head;
    logic               full;
    logic               empty;
    logic               push;
    logic               steer;
    logic               head_in_range;
    logic [BEATS_W-1:0] beat_cnt;

    assign push_entry = '{master: rd_master, len: rd_len};
    assign rd_ready   = !full;
    assign push       = rd_req && rd_ready;
    assign steer      = resp && !empty;
    assign resp_last  = steer && (beat_cnt == head.len);

    // IDs beyond the master count are kept in the queue but steer nowhere.
    assign head_in_range = ({1'b0, head.master} < (MSEL_W + 1)'(MASTER_NUM));

    resp_id_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_id_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .pop   (resp_last),
        .din   (push_entry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    // One-hot steering of the current beat to the head request's master.
    always_comb begin
        resp_en = '0;
        if (steer && head_in_range) resp_en[head.master] = 1'b1;
    end

    // Beat counter walks the head burst and restarts when the burst retires.
    always_ff @(posedge aclk) begin
        if (areset)         beat_cnt <= '0;
        else if (resp_last) beat_cnt <= '0;
        else if (steer)     beat_cnt <= beat_cnt + 1'b1;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            if (resp && empty)     err_unexpected <= 1'b1;
            if (rd_req && !rd_ready) err_overflow <= 1'b1;
        end
    end

endmodule
